// File: rtl/sep_conv_k.sv
// Separable KxK convolution over a pixel stream: row pass into a K-row line store, column pass to a 1-cycle output register.
// o_rdy = i_rdy | ~o_vld; define SEP_CONV_ROUND_EN for round-half-up before each shift.
module sep_conv_k #(
  parameter int DATA_W    = 8,
  parameter int KERNEL_K  = 7,
  parameter int COEF_W    = 5,
  parameter logic [KERNEL_K*COEF_W-1:0] WEIGHTS =
    {5'd7, 5'b11010, 5'd5, 5'b11100, 5'd3, 5'b11110, 5'd1},
  parameter int SHIFT     = 0,
  parameter int MAX_IMG_W = 640
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rdy,
  input  logic              i_vld,
  input  logic              i_eor,
  input  logic              i_eof,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rdy,
  output logic              o_vld,
  output logic              o_eor,
  output logic              o_eof,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);
  localparam int AW  = DATA_W + COEF_W + $clog2(KERNEL_K) + 1;
  localparam int CW  = $clog2(MAX_IMG_W + 1);
  localparam int AIW = (MAX_IMG_W > 1) ? $clog2(MAX_IMG_W) : 1;
  localparam int RW  = $clog2(KERNEL_K);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_K - 1);
  localparam logic [CW-1:0] COL_LIMIT = CW'(MAX_IMG_W);
  localparam logic [RW-1:0] ROW_LAST  = RW'(KERNEL_K - 1);
  localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << DATA_W) - 1);
`ifdef SEP_CONV_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'((1 << SHIFT) >> 1);
`endif

  function automatic logic signed [AW-1:0] mul(input logic [COEF_W-1:0] w,
                                               input logic [DATA_W-1:0] x);
    logic signed [AW-1:0] ws;
    logic signed [AW-1:0] xs;
    ws = AW'(signed'(w));
    xs = AW'(signed'({1'b0, x}));
    return ws * xs;
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
`ifdef SEP_CONV_ROUND_EN
    s = (a + RND) >>> SHIFT;
`else
    s = a >>> SHIFT;
`endif
    if (s[AW-1])
      return '0;
    else if (s > PIX_MAX)
      return '1;
    else
      return s[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] win_q [KERNEL_K-1];
  logic [DATA_W-1:0] line_q [KERNEL_K][MAX_IMG_W];
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     slot_q, slot_d;
  logic              vld_q, vld_d, eor_q, eor_d, eof_q, eof_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              accept, in_row, win_go, load;
  logic [AIW-1:0]    col_idx;
  logic signed [AW-1:0] h_acc, v_acc;
  logic [DATA_W-1:0] h_pix, v_pix;

  assign o_rdy   = i_rdy | ~vld_q;
  assign accept  = i_vld & o_rdy;
  assign in_row  = col_q < COL_LIMIT;
  assign win_go  = accept & in_row & (col_q >= COL_FIRST);
  assign load    = win_go & (row_q == ROW_LAST);
  assign col_idx = AIW'(col_q);

  always_comb begin
    h_acc = mul(WEIGHTS[(KERNEL_K-1)*COEF_W +: COEF_W], i_data);
    for (int j = 0; j < KERNEL_K - 1; j++)
      h_acc = h_acc + mul(WEIGHTS[j*COEF_W +: COEF_W], win_q[j]);
  end
  assign h_pix = scale(h_acc);

  // Oldest row sits in slot (slot_q+1) mod K; the newest row is the one being computed now.
  always_comb begin
    logic [RW-1:0] rd_slot;
    rd_slot = '0;
    v_acc   = mul(WEIGHTS[(KERNEL_K-1)*COEF_W +: COEF_W], h_pix);
    for (int j = 0; j < KERNEL_K - 1; j++) begin
      rd_slot = RW'((int'(slot_q) + 1 + j) % KERNEL_K);
      v_acc   = v_acc + mul(WEIGHTS[j*COEF_W +: COEF_W], line_q[rd_slot][col_idx]);
    end
  end
  assign v_pix = scale(v_acc);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    slot_d = slot_q;
    err_d  = err_q;
    vld_d  = vld_q;
    eor_d  = eor_q;
    eof_d  = eof_q;
    data_d = data_q;
    if (accept) begin
      if (i_eor) begin
        col_d = '0;
        if (i_eof) begin
          row_d  = '0;
          slot_d = '0;
        end else begin
          // Row count only needs to know "at least K-1 rows seen", so it saturates.
          if (row_q != ROW_LAST) row_d = row_q + 1'b1;
          slot_d = (slot_q == ROW_LAST) ? '0 : slot_q + 1'b1;
        end
      end else if (in_row) begin
        col_d = col_q + 1'b1;
      end
      if (!in_row) err_d = 1'b1;
    end
    if (load) begin
      vld_d  = 1'b1;
      eor_d  = i_eor;
      eof_d  = i_eof;
      data_d = v_pix;
    end else if (i_rdy) begin
      vld_d = 1'b0;
      eor_d = 1'b0;
      eof_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      slot_q <= '0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      eor_q  <= 1'b0;
      eof_q  <= 1'b0;
      data_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      slot_q <= slot_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
      eor_q  <= eor_d;
      eof_q  <= eof_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < KERNEL_K - 2; i++) win_q[i] <= win_q[i+1];
      win_q[KERNEL_K-2] <= i_data;
    end
    if (win_go) line_q[slot_q][col_idx] <= h_pix;
  end

  assign o_vld  = vld_q;
  assign o_eor  = eor_q;
  assign o_eof  = eof_q;
  assign o_data = data_q;
  assign o_err  = err_q;
endmodule
